// File: rtl/mux_capture_pkg.sv
// Shared types and constants for the mux byte capture path.
// The MUX_CAPTURE_CONTINUOUS_EN macro is consumed by mux_byte_capture.
package mux_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_SETTLE = 1;

    // Ceiling log2, never below 1 so derived vectors stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_settle_counter.sv
// Loadable down-counter timing how long the mux select is held.
// Stops at zero and flags it.
module mux_settle_counter
#(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux_byte_capture.sv
// Walks an external bit-select mux and reassembles the selected word.
// Define MUX_CAPTURE_CONTINUOUS_EN to restart capture after each handshake.
module mux_byte_capture
    import mux_capture_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SEL_W  = clog2(WIDTH),
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    output logic             EN_0,
    output logic [SEL_W-1:0] S,
    input  logic             BIT_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID,
    input  logic             READY,
    output logic             BUSY
);

    localparam int CNT_W = clog2(SETTLE + 1);
    localparam logic [SEL_W-1:0] S_LAST   = SEL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

`ifdef MUX_CAPTURE_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] merged;
    logic             last;
    logic             handshake;
    logic             restart;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;

    assign last      = (S == S_LAST);
    assign handshake = (state == ST_DONE) && VALID && READY;
    assign restart   = CONT && handshake;

    // Final bit folded in so the word lands on DATA_OUT in one step.
    always_comb begin
        merged    = shadow;
        merged[S] = BIT_IN;
    end

    assign cnt_load = ((state == ST_IDLE) && START)
                    || ((state == ST_SAMPLE) && !last)
                    || restart;
    assign cnt_en   = (state == ST_SETTLE);

    mux_settle_counter #(
        .W (CNT_W)
    ) u_settle (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (CNT_INIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            S        <= '0;
            EN_0     <= 1'b0;
            DATA_OUT <= '0;
            VALID    <= 1'b0;
            BUSY     <= 1'b0;
            shadow   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (START) begin
                        state <= ST_SETTLE;
                        S     <= '0;
                        EN_0  <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    shadow[S] <= BIT_IN;
                    if (!last) begin
                        S     <= S + 1'b1;
                        state <= ST_SETTLE;
                    end else begin
                        DATA_OUT <= merged;
                        VALID    <= 1'b1;
                        EN_0     <= 1'b0;
                        S        <= '0;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (handshake) begin
                        VALID <= 1'b0;
                        if (restart) begin
                            state <= ST_SETTLE;
                            S     <= '0;
                            EN_0  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_byte_capture.sv
// Directed bench: an 8:1 mux model feeds two capture instances.
// Build with MUX_CAPTURE_CONTINUOUS_EN to exercise continuous mode.
module tb_mux_byte_capture;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic       EN_0;
    logic [2:0] S;
    logic       BIT_IN;
    logic [7:0] DATA_OUT;
    logic       VALID;
    logic       READY;
    logic       BUSY;
    logic [7:0] data_in;

    logic       start3;
    logic       en3;
    logic [2:0] s3;
    logic       bit3;
    logic [7:0] dout3;
    logic       valid3;
    logic       ready3;
    logic       busy3;
    logic [7:0] data3;

    int n_vec = 0;
    int n_bad = 0;

    // 8:1 bit-select mux, output grounded when disabled
    assign BIT_IN = EN_0 ? data_in[S] : 1'b0;
    assign bit3   = en3 ? data3[s3] : 1'b0;

    mux_byte_capture u_dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .EN_0     (EN_0),
        .S        (S),
        .BIT_IN   (BIT_IN),
        .DATA_OUT (DATA_OUT),
        .VALID    (VALID),
        .READY    (READY),
        .BUSY     (BUSY)
    );

    mux_byte_capture #(
        .SETTLE (3)
    ) u_s3 (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (start3),
        .EN_0     (en3),
        .S        (s3),
        .BIT_IN   (bit3),
        .DATA_OUT (dout3),
        .VALID    (valid3),
        .READY    (ready3),
        .BUSY     (busy3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic capture(input logic [7:0] d, input bit hold,
                           output int edges);
        data_in = d;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        if (!hold) START = 1'b0;
        edges = 0;
        while (!VALID && edges < 100) begin
            @(posedge CLK);
            #1;
            edges++;
        end
    endtask

    int edges;
    int n;

    initial begin
        RST_N   = 1'b0;
        START   = 1'b0;
        READY   = 1'b0;
        data_in = 8'h00;
        start3  = 1'b0;
        ready3  = 1'b1;
        data3   = 8'h5A;

        repeat (2) @(negedge CLK);
        check("rst_s", 32'(S), 0);
        check("rst_en", 32'(EN_0), 0);
        check("rst_dout", 32'(DATA_OUT), 0);
        check("rst_valid", 32'(VALID), 0);
        check("rst_busy", 32'(BUSY), 0);
        RST_N = 1'b1;
        @(negedge CLK);

`ifndef MUX_CAPTURE_CONTINUOUS_EN
        // basic capture, consumer always ready
        READY = 1'b1;
        capture(8'hA5, 1'b0, edges);
        check("t1_latency", 32'(edges), 16);
        check("t1_dout", 32'(DATA_OUT), 32'hA5);
        check("t1_en", 32'(EN_0), 0);
        check("t1_s", 32'(S), 0);
        check("t1_busy_done", 32'(BUSY), 1);
        @(posedge CLK);
        #1;
        check("t1_valid_fall", 32'(VALID), 0);
        check("t1_idle", 32'(BUSY), 0);

        // back-pressure holds the word
        READY = 1'b0;
        capture(8'h01, 1'b0, edges);
        check("t2_latency", 32'(edges), 16);
        check("t2_dout01", 32'(DATA_OUT), 32'h01);
        n = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (!VALID || DATA_OUT !== 8'h01) n++;
        end
        check("t2_hold", 32'(n), 0);
        @(negedge CLK);
        READY = 1'b1;
        @(posedge CLK);
        #1;
        check("t2_valid_fall", 32'(VALID), 0);
        READY = 1'b0;
        capture(8'h80, 1'b0, edges);
        check("t2_dout80", 32'(DATA_OUT), 32'h80);
        @(negedge CLK);
        READY = 1'b1;
        @(posedge CLK);
        #1;
        check("t2b_valid_fall", 32'(VALID), 0);
        READY = 1'b0;

        // START held high through the capture and the handshake
        capture(8'hC3, 1'b1, edges);
        check("t3_latency", 32'(edges), 16);
        check("t3_dout", 32'(DATA_OUT), 32'hC3);
        @(negedge CLK);
        READY = 1'b1;
        @(posedge CLK);
        #1;
        check("t3_valid_fall", 32'(VALID), 0);
        check("t3_idle", 32'(BUSY), 0);
        START = 1'b0;
        READY = 1'b0;
        @(posedge CLK);
        #1;
        check("t3_stay_idle", 32'(BUSY), 0);
        check("t3_en_off", 32'(EN_0), 0);

        // reset in the middle of a capture
        READY   = 1'b1;
        data_in = 8'hFF;
        @(negedge CLK);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        n = 0;
        while (S != 3'd3 && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("t4_reach_s3", 32'(S), 3);
        #2;
        RST_N = 1'b0;
        #1;
        check("t4_s", 32'(S), 0);
        check("t4_en", 32'(EN_0), 0);
        check("t4_valid", 32'(VALID), 0);
        check("t4_busy", 32'(BUSY), 0);
        check("t4_dout", 32'(DATA_OUT), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("t4_idle_after", 32'(BUSY), 0);
        capture(8'h3C, 1'b0, edges);
        check("t4_latency", 32'(edges), 16);
        check("t4_dout", 32'(DATA_OUT), 32'h3C);
        @(posedge CLK);
        #1;
`else
        // continuous mode: one START, words back to back
        READY = 1'b1;
        capture(8'hFF, 1'b0, edges);
        check("t5_latency", 32'(edges), 16);
        check("t5_dout_ff", 32'(DATA_OUT), 32'hFF);
        data_in = 8'h00;
        @(posedge CLK);
        #1;
        check("t5_valid_fall", 32'(VALID), 0);
        check("t5_restart_en", 32'(EN_0), 1);
        edges = 1;
        while (!VALID && edges < 100) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        check("t5_spacing", 32'(edges), 17);
        check("t5_dout_00", 32'(DATA_OUT), 32'h00);
`endif

        // SETTLE=3 instance
        @(negedge CLK);
        start3 = 1'b1;
        @(posedge CLK);
        #1;
        start3 = 1'b0;
        begin
            int e3;
            int run;
            int chg;
            int bad;
            logic [2:0] prev;
            e3   = 0;
            run  = 0;
            chg  = 0;
            bad  = 0;
            prev = s3;
            while (!valid3 && e3 < 200) begin
                @(posedge CLK);
                #1;
                e3++;
                run++;
                if (s3 != prev) begin
                    if (run != 4) bad++;
                    chg++;
                    run  = 0;
                    prev = s3;
                end
            end
            check("t6_latency", 32'(e3), 32);
            check("t6_hold4", 32'(bad), 0);
            check("t6_steps", 32'(chg), 8);
            check("t6_dout", 32'(dout3), 32'h5A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
